rx_frame_buffer: RTL and testbench
==================================

Name: rx_frame_buffer

Overview:
Single-frame store-and-forward buffer between the receive MAC and the transmit controller of the bridge. Captures one received Ethernet frame byte-by-byte, commits its length on end-of-frame, then serves the bytes to the transmit controller one per read strobe. Frames arriving while a committed frame is still being drained are dropped and counted.

Parameters:
ADDR_W, 11, byte address width; buffer depth is 2**ADDR_W bytes (2048).
MIN_LEN, 16'd64, minimum legal frame length in bytes; shorter frames are handled per Optional Feature.
CNT_W, 8, width of the dropped-frame counter.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous active-low reset.
rx_data  input  8  received byte from MAC.
rx_valid  input  1  rx_data valid this cycle.
rx_last  input  1  qualifies the final byte of a frame (with rx_valid).
rx_err  input  1  MAC error on current frame; sampled when rx_valid=1.
next_byte  input  1  read strobe from transmit controller; one byte per high cycle.
tx_data  output  8  byte read from buffer.
frm_len  output  16  committed frame length in bytes.
empty_buff  output  1  high when no committed bytes remain.
rx_frame  output  1  one-cycle pulse when a frame is committed.
drop_cnt  output  CNT_W  frames dropped (busy, overflow, error); saturates.

Behaviour:
- Reset (rst=0, async): wr_ptr=0, rd_ptr=0, state=IDLE, tx_data=8'h00, frm_len=0, empty_buff=1, rx_frame=0, drop_cnt=0. Memory contents not reset. Reset mid-frame discards the partial frame; no pulse, no count.
- States: IDLE, RECV, DISCARD, READY.
- IDLE: first rx_valid byte written at address 0, wr_ptr=1, go RECV; if that byte also has rx_last, commit immediately (length 1) unless rx_err. Byte with rx_err=1 -> DISCARD.
- RECV: each rx_valid byte written at wr_ptr, wr_ptr+1. rx_valid&rx_last: commit -> frm_len<=wr_ptr+1 (16-bit zero-extended), rx_frame=1 next cycle only, empty_buff<=0, rd_ptr<=0, go READY.
- RECV overflow: byte arriving when wr_ptr==2**ADDR_W-1 without rx_last is not committed; go DISCARD, drop_cnt+1. A frame of exactly 2**ADDR_W bytes ending on the last address commits.
- rx_err=1 on any valid byte in RECV -> DISCARD, drop_cnt+1 (error on the rx_last byte also drops).
- DISCARD: ignore bytes until rx_valid&rx_last, then IDLE, wr_ptr=0. frm_len, empty_buff unchanged.
- READY: rx_valid bytes ignored; first byte of a new frame marks it dropped: drop_cnt+1 once per frame (count on its rx_last, or on first byte if single-byte frame), no memory write.
- Read: in READY with next_byte=1 and rd_ptr<frm_len: tx_data<=mem[rd_ptr], rd_ptr+1; 1-cycle latency, tx_data holds between strobes. When strobe consumes byte frm_len-1, empty_buff<=1 same edge as tx_data update, state->IDLE, wr_ptr=0. next_byte while empty_buff=1: ignored, tx_data holds.
- A frame starting the cycle after return to IDLE is accepted; start coincident with final strobe edge (still READY) is dropped.
- frm_len holds until next commit; not cleared on drain.
- drop_cnt saturates at all-ones.
- rx_frame never asserted for dropped frames.

Optional Feature:
Macro RX_BUF_PAD_EN.
- Defined: frames committed with length < MIN_LEN are padded: frm_len reported as MIN_LEN; reads beyond the received length return 8'h00 (memory not written; a received-length register selects zero).
- Undefined: short frames are dropped in RECV at rx_last, drop_cnt+1, no rx_frame, state->IDLE.

Test Plan:
- 64-byte frame 0x00..0x3F, rx_last on byte 64 -> rx_frame pulse 1 cycle, frm_len=64, empty_buff=0; 64 strobes return 0x00..0x3F one cycle after each strobe, empty_buff=1 with last byte.
- Second 70-byte frame sent while first in READY -> drop_cnt=1, frm_len stays 64, data of first frame intact.
- rx_err on byte 10 of 100-byte frame -> no rx_frame, drop_cnt+1, next good 80-byte frame commits frm_len=80.
- 2049-byte frame -> dropped at overflow, drop_cnt+1; 2048-byte frame -> frm_len=2048, last read returns byte 2047.
- 20-byte frame: RX_BUF_PAD_EN defined -> frm_len=64, bytes 20..63 read 8'h00; undefined -> dropped, drop_cnt+1.
- rst asserted mid-RECV at byte 30 and mid-drain at byte 12 -> all outputs reset values immediately; next frame commits normally from address 0.

Source files
------------

// File: rtl/rx_frame_buffer.sv
// Single-frame store-and-forward buffer: captures one MAC frame, commits its length, serves bytes on next_byte.
// Optional macro RX_BUF_PAD_EN: short frames are padded to MIN_LEN with zero bytes instead of being dropped.
//
// state   | meaning
// IDLE    | buffer free, waiting for first byte of a frame
// RECV    | storing bytes of the current frame
// DISCARD | skipping the rest of a dropped frame until rx_last
// READY   | committed frame being drained; new frames are dropped
module rx_frame_buffer #(
   parameter int          ADDR_W  = 11,
   parameter logic [15:0] MIN_LEN = 16'd64,
   parameter int          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_last,
   input  logic             rx_err,
   input  logic             next_byte,
   output logic [7:0]       tx_data,
   output logic [15:0]      frm_len,
   output logic             empty_buff,
   output logic             rx_frame,
   output logic [CNT_W-1:0] drop_cnt
);

`ifdef RX_BUF_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] WR_MAX = '1;

   typedef enum logic [1:0] {IDLE, RECV, DISCARD, READY} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [15:0]       rd_ptr;
   logic              in_drop, in_drop_nxt;
   logic              wr_en, commit, drop_inc, rd_en, last_rd;
   logic [15:0]       len_new;
   logic [7:0]        rd_data;
   logic [7:0]        mem [2**ADDR_W];

   assign len_new = 16'(wr_ptr) + 16'd1;

`ifdef RX_BUF_PAD_EN
   logic [15:0] rx_len;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        rx_len <= 16'd0;
      else if (commit) rx_len <= len_new;
   end

   // bytes past the received length read as zero padding
   assign rd_data = (rd_ptr >= rx_len) ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];
`else
   assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
`endif

   always_comb begin
      state_nxt   = state;
      wr_ptr_nxt  = wr_ptr;
      in_drop_nxt = in_drop;
      wr_en       = 1'b0;
      commit      = 1'b0;
      drop_inc    = 1'b0;
      rd_en       = 1'b0;
      last_rd     = 1'b0;
      case (state)
         IDLE, RECV: begin
            if (rx_valid) begin
               if (rx_err) begin
                  drop_inc   = 1'b1;
                  wr_ptr_nxt = '0;
                  state_nxt  = rx_last ? IDLE : DISCARD;
               end else if (rx_last) begin
                  wr_en      = 1'b1;
                  wr_ptr_nxt = '0;
                  if (!PAD_EN && (len_new < MIN_LEN)) begin
                     drop_inc  = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     commit    = 1'b1;
                     state_nxt = READY;
                  end
               end else if (wr_ptr == WR_MAX) begin
                  drop_inc   = 1'b1;
                  wr_ptr_nxt = '0;
                  state_nxt  = DISCARD;
               end else begin
                  wr_en      = 1'b1;
                  wr_ptr_nxt = wr_ptr + ADDR_W'(1);
                  state_nxt  = RECV;
               end
            end
         end
         DISCARD: begin
            if (rx_valid && rx_last) begin
               wr_ptr_nxt = '0;
               state_nxt  = IDLE;
            end
         end
         READY: begin
            if (rx_valid) begin
               if (rx_last) begin
                  drop_inc    = 1'b1;
                  in_drop_nxt = 1'b0;
               end else begin
                  in_drop_nxt = 1'b1;
               end
            end
            if (next_byte && !empty_buff) begin
               rd_en = 1'b1;
               if (rd_ptr == frm_len - 16'd1) begin
                  last_rd    = 1'b1;
                  wr_ptr_nxt = '0;
                  // a blocked frame still in flight is counted now and its tail skipped
                  if (in_drop_nxt) begin
                     drop_inc    = 1'b1;
                     in_drop_nxt = 1'b0;
                     state_nxt   = DISCARD;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= 16'd0;
         in_drop    <= 1'b0;
         tx_data    <= 8'h00;
         frm_len    <= 16'd0;
         empty_buff <= 1'b1;
         rx_frame   <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         state    <= state_nxt;
         wr_ptr   <= wr_ptr_nxt;
         in_drop  <= in_drop_nxt;
         rx_frame <= commit;
         if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
         if (commit) begin
            frm_len    <= (len_new < MIN_LEN) ? MIN_LEN : len_new;
            empty_buff <= 1'b0;
            rd_ptr     <= 16'd0;
         end
         if (rd_en) begin
            tx_data <= rd_data;
            rd_ptr  <= rd_ptr + 16'd1;
            if (last_rd) empty_buff <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: vector table for drain/drop interleaving plus frame-level sequences.
// Short-frame expectations follow RX_BUF_PAD_EN when the bench is built with it.
module tb_rx_frame_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0, rx_last = 1'b0, rx_err = 1'b0, next_byte = 1'b0;
   logic [7:0]  tx_data;
   logic [15:0] frm_len;
   logic        empty_buff, rx_frame;
   logic [7:0]  drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;
   int exp_drop = 0;
   int p0;

   typedef struct {
      logic       v, l, nb;
      logic [7:0] tx;
      logic [15:0] len;
      logic       empty, frame;
      logic [7:0] drop;
   } vec_t;

   vec_t tbl [7];

   rx_frame_buffer dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
      .rx_err(rx_err), .next_byte(next_byte), .tx_data(tx_data), .frm_len(frm_len),
      .empty_buff(empty_buff), .rx_frame(rx_frame), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rx_frame === 1'b1) pulses++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] pat(input int i, input int seed);
      return 8'(i + (i >> 8) + seed);
   endfunction

   task automatic send_frame(input int len, input int err_at, input int seed);
      for (int i = 0; i < len; i++) begin
         rx_valid = 1'b1;
         rx_data  = pat(i, seed);
         rx_last  = (i == len - 1);
         rx_err   = (i == err_at);
         step();
      end
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      rx_err   = 1'b0;
   endtask

   task automatic commit_frame(input int len, input int exp_len, input int seed, input string name);
      p0 = pulses;
      send_frame(len, -1, seed);
      chk({name, "_frame"}, rx_frame, 1);
      chk({name, "_len"}, frm_len, exp_len);
      chk({name, "_empty"}, empty_buff, 0);
      step();
      chk({name, "_frame_off"}, rx_frame, 0);
      chk({name, "_pulses"}, pulses - p0, 1);
   endtask

   task automatic read_bytes(input int first, input int n, input int len, input int rlen,
                             input int seed, input string name);
      for (int i = first; i < first + n; i++) begin
         next_byte = 1'b1;
         step();
         next_byte = 1'b0;
         chk({name, "_data"}, tx_data, (i < rlen) ? pat(i, seed) : 8'h00);
         chk({name, "_empty"}, empty_buff, (i == len - 1) ? 1 : 0);
      end
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_tx"}, tx_data, 0);
      chk({name, "_len"}, frm_len, 0);
      chk({name, "_empty"}, empty_buff, 1);
      chk({name, "_frame"}, rx_frame, 0);
      chk({name, "_drop"}, drop_cnt, 0);
   endtask

   initial begin
      //           v     l     nb    tx     len     empty frame drop
      tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h00, 16'd64, 1'b0, 1'b0, 8'd1};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 16'd64, 1'b0, 1'b0, 8'd1};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h01, 16'd64, 1'b0, 1'b0, 8'd1};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h02, 16'd64, 1'b0, 1'b0, 8'd1};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h02, 16'd64, 1'b0, 1'b0, 8'd2};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 8'h02, 16'd64, 1'b0, 1'b0, 8'd3};
      tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h03, 16'd64, 1'b0, 1'b0, 8'd3};

      #1 rst = 1'b0;
      #1 chk_reset("por");
      @(posedge clk);
      #1 rst = 1'b1;

      commit_frame(64, 64, 0, "f64");

      // 70-byte frame while busy
      p0 = pulses;
      send_frame(70, -1, 8'h80);
      exp_drop++;
      chk("busy_drop", drop_cnt, exp_drop);
      chk("busy_len", frm_len, 64);
      chk("busy_empty", empty_buff, 0);
      chk("busy_pulses", pulses - p0, 0);

      for (int k = 0; k < 7; k++) begin
         rx_valid  = tbl[k].v;
         rx_last   = tbl[k].l;
         rx_data   = 8'hEE;
         next_byte = tbl[k].nb;
         step();
         rx_valid = 1'b0; rx_last = 1'b0; next_byte = 1'b0;
         chk("vec_tx", tx_data, tbl[k].tx);
         chk("vec_len", frm_len, tbl[k].len);
         chk("vec_empty", empty_buff, tbl[k].empty);
         chk("vec_frame", rx_frame, tbl[k].frame);
         chk("vec_drop", drop_cnt, tbl[k].drop);
      end
      exp_drop = 3;

      read_bytes(4, 60, 64, 64, 0, "drain64");
      step();
      next_byte = 1'b1;
      step();
      next_byte = 1'b0;
      chk("empty_strobe_tx", tx_data, 8'h3F);
      chk("empty_strobe_empty", empty_buff, 1);
      chk("len_hold", frm_len, 64);

      // error on byte 10
      p0 = pulses;
      send_frame(100, 9, 8'h10);
      exp_drop++;
      chk("err_drop", drop_cnt, exp_drop);
      chk("err_pulses", pulses - p0, 0);
      commit_frame(80, 80, 8'h20, "f80");
      read_bytes(0, 79, 80, 80, 8'h20, "drain80");

      // new frame starts on the final strobe edge: must be dropped
      p0 = pulses;
      next_byte = 1'b1;
      rx_valid  = 1'b1;
      rx_data   = pat(0, 8'h30);
      step();
      next_byte = 1'b0;
      chk("final_tx", tx_data, pat(79, 8'h20));
      chk("final_empty", empty_buff, 1);
      for (int i = 1; i < 64; i++) begin
         rx_valid = 1'b1;
         rx_data  = pat(i, 8'h30);
         rx_last  = (i == 63);
         step();
      end
      rx_valid = 1'b0; rx_last = 1'b0;
      exp_drop++;
      chk("coinc_drop", drop_cnt, exp_drop);
      chk("coinc_pulses", pulses - p0, 0);
      chk("coinc_empty", empty_buff, 1);
      chk("coinc_len", frm_len, 80);

      // overflow and exact-depth frames
      p0 = pulses;
      send_frame(2049, -1, 3);
      exp_drop++;
      chk("ovf_drop", drop_cnt, exp_drop);
      chk("ovf_pulses", pulses - p0, 0);
      commit_frame(2048, 2048, 5, "f2048");
      read_bytes(0, 2048, 2048, 2048, 5, "drain2048");

`ifdef RX_BUF_PAD_EN
      commit_frame(20, 64, 7, "short");
      read_bytes(0, 64, 64, 20, 7, "pad");
`else
      p0 = pulses;
      send_frame(20, -1, 7);
      exp_drop++;
      chk("short_drop", drop_cnt, exp_drop);
      chk("short_pulses", pulses - p0, 0);
      chk("short_len", frm_len, 2048);
      chk("short_empty", empty_buff, 1);
`endif

      // reset mid-RECV at byte 30
      for (int i = 0; i < 30; i++) begin
         rx_valid = 1'b1;
         rx_data  = pat(i, 8'h40);
         step();
      end
      rx_valid = 1'b0;
      rst = 1'b0;
      #1 chk_reset("rst_recv");
      @(posedge clk);
      #1 rst = 1'b1;
      commit_frame(64, 64, 9, "after_rst1");
      read_bytes(0, 12, 64, 64, 9, "pre_rst2");

      // reset mid-drain
      rst = 1'b0;
      #1 chk_reset("rst_drain");
      @(posedge clk);
      #1 rst = 1'b1;
      commit_frame(64, 64, 11, "after_rst2");
      read_bytes(0, 1, 64, 64, 11, "post_rst2");

      // saturate drop counter with single-byte frames while busy
      for (int i = 0; i < 260; i++) begin
         rx_valid = 1'b1;
         rx_last  = 1'b1;
         step();
      end
      rx_valid = 1'b0; rx_last = 1'b0;
      chk("sat_drop", drop_cnt, 8'hFF);
      chk("sat_len", frm_len, 64);
      chk("sat_empty", empty_buff, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
